regfile_write_arbiter: RTL

- Owns the single write port of the 32x32 register file.
- Shares that port between the in-order WB stage and a long-latency unit (LLU, e.g. mul/div). WB has priority.
- Keeps a per-register busy scoreboard for LLU destinations and raises a decode stall on RAW/WAW hazards.
- Includes a starvation guard: if the LLU is blocked too long, the pipeline is frozen for one grant.

---
 rtl/regfile_write_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Single write-port arbiter for the register file: WB has priority over the
// long-latency unit, with a busy scoreboard and a starvation-breaking pipe hold.
module regfile_write_arbiter #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              llu_issue,
    input  logic [ADDR_W-1:0] llu_issue_rd,
    input  logic              llu_valid,
    input  logic [ADDR_W-1:0] llu_rd,
    input  logic [DATA_W-1:0] llu_data,
    output logic              llu_ready,
    input  logic              dec_valid,
    input  logic [ADDR_W-1:0] dec_rs1,
    input  logic [ADDR_W-1:0] dec_rs2,
    input  logic [ADDR_W-1:0] dec_rd,
    output logic              hazard_stall,
    output logic              pipe_hold,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [NREGS-1:0]  busy
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   wait_cnt, wait_cnt_nx;
    logic               wb_eff;
    logic               llu_grant;
    logic               wr_en_nx;
    logic               wr_llu_nx;
    logic [ADDR_W-1:0]  wr_addr_nx;
    logic [DATA_W-1:0]  wr_data_nx;
    logic               rf_llu;

    assign wb_eff    = wb_we && (wb_waddr != '0);
    assign pipe_hold = (state == HOLD);
    assign llu_grant = llu_valid && llu_ready;

    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        llu_ready   = !wb_eff;
        case (state)
            IDLE: begin
                if (llu_valid && wb_eff) begin
                    state_nx    = WAIT;
                    wait_cnt_nx = CNT_W'(1);
                end
            end
            WAIT: begin
                if (llu_valid && !wb_eff) begin
                    state_nx    = IDLE;
                    wait_cnt_nx = '0;
                end else if (llu_valid) begin
                    wait_cnt_nx = wait_cnt + CNT_W'(1);
                    if (wait_cnt + CNT_W'(1) == CNT_W'(MAX_WAIT))
                        state_nx = HOLD;
                end
            end
            HOLD: begin
                llu_ready = 1'b1;
                if (llu_valid) begin
                    state_nx    = IDLE;
                    wait_cnt_nx = '0;
                end
            end
            default: begin
                state_nx    = IDLE;
                wait_cnt_nx = '0;
            end
        endcase
    end

    // WB loses the port only while the pipe is held; LLU writes to x0 are swallowed
    always_comb begin
        wr_en_nx   = 1'b0;
        wr_llu_nx  = 1'b0;
        wr_addr_nx = '0;
        wr_data_nx = '0;
        if (wb_eff && state != HOLD) begin
            wr_en_nx   = 1'b1;
            wr_addr_nx = wb_waddr;
            wr_data_nx = wb_wdata;
        end else if (llu_grant && llu_rd != '0) begin
            wr_en_nx   = 1'b1;
            wr_llu_nx  = 1'b1;
            wr_addr_nx = llu_rd;
            wr_data_nx = llu_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
            rf_we    <= 1'b0;
            rf_llu   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
            rf_we    <= wr_en_nx;
            rf_llu   <= wr_llu_nx;
            if (wr_en_nx) begin
                rf_waddr <= wr_addr_nx;
                rf_wdata <= wr_data_nx;
            end
        end
    end

    // Clear lands at the edge that commits the LLU write; a same-edge issue re-sets it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            logic [NREGS-1:0] b;
            b = busy;
            if (rf_we && rf_llu)
                b[rf_waddr] = 1'b0;
            if (llu_issue && llu_issue_rd != '0)
                b[llu_issue_rd] = 1'b1;
            b[0] = 1'b0;
            busy <= b;
        end
    end

    assign hazard_stall = dec_valid && (busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd]);

endmodule
